// File: rtl/snn_mem_pkg.sv
// Shared types, default tile geometry and width helpers for the SNN tile memory.
package snn_mem_pkg;

    localparam int DEF_TIMESTEPS   = 10;
    localparam int DEF_F_ROWS      = 3;
    localparam int DEF_F_COLS      = 3;
    localparam int DEF_F_WIDTH     = 8;
    localparam int DEF_IF_ROWS     = 5;
    localparam int DEF_IF_COLS     = 5;
    localparam int DEF_OF_ROWS     = 3;
    localparam int DEF_OF_COLS     = 3;
    localparam int DEF_V_POT_WIDTH = 8;

    typedef enum logic [1:0] {
        LD_FILTER = 2'd0,
        LD_IFMAP  = 2'd1,
        LD_GOLDEN = 2'd2
    } ld_type_e;

    typedef enum logic [1:0] {
        RD_VPOT   = 2'd0,
        RD_IFMAP  = 2'd1,
        RD_FILTER = 2'd2
    } rd_type_e;

    typedef enum logic {
        WR_VPOT    = 1'b0,
        WR_OFSPIKE = 1'b1
    } wr_type_e;

    typedef enum logic [1:0] {
        CMP_IDLE = 2'd0,
        CMP_SCAN = 2'd1,
        CMP_DONE = 2'd2
    } cmp_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/snn_golden_cmp.sv
// Walks the last-timestep output spikes against the golden map, one entry per cycle,
// and holds the mismatch count once the walk is finished.
//
//  state    | meaning
//  CMP_IDLE | waiting for start (rising edge of done)
//  CMP_SCAN | comparing entry idx, counting mismatches
//  CMP_DONE | result valid, held until reset
module snn_golden_cmp
    import snn_mem_pkg::*;
#(
    parameter int N  = DEF_OF_ROWS * DEF_OF_COLS,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  observed,
    input  logic [N-1:0]  expected,
    output logic          cmp_done,
    output logic [CW-1:0] mismatch_cnt
);

    localparam int IW = addr_width(N);

    cmp_state_e    state;
    logic [IW-1:0] idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CMP_IDLE;
            idx          <= '0;
            cmp_done     <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            case (state)
                CMP_IDLE: begin
                    if (start) begin
                        state <= CMP_SCAN;
                        idx   <= '0;
                    end
                end
                CMP_SCAN: begin
                    if (observed[idx] != expected[idx])
                        mismatch_cnt <= mismatch_cnt + 1'b1;
                    if (idx == IW'(N - 1)) begin
                        state    <= CMP_DONE;
                        cmp_done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/snn_tile_mem.sv
// Clocked storage for one SNN conv tile: filter, per-timestep ifmap, V_pot and output spikes.
// Define SNN_TILE_MEM_GOLDEN_CMP_EN to add golden storage and the end-of-run comparison.
module snn_tile_mem
    import snn_mem_pkg::*;
#(
    parameter int TIMESTEPS   = DEF_TIMESTEPS,
    parameter int F_ROWS      = DEF_F_ROWS,
    parameter int F_COLS      = DEF_F_COLS,
    parameter int F_WIDTH     = DEF_F_WIDTH,
    parameter int IF_ROWS     = DEF_IF_ROWS,
    parameter int IF_COLS     = DEF_IF_COLS,
    parameter int OF_ROWS     = DEF_OF_ROWS,
    parameter int OF_COLS     = DEF_OF_COLS,
    parameter int V_POT_WIDTH = DEF_V_POT_WIDTH,
    parameter int DW   = max_int(F_WIDTH, V_POT_WIDTH),
    parameter int RC_W = $clog2(max_int(max_int(max_int(F_ROWS, F_COLS), max_int(IF_ROWS, IF_COLS)),
                                        max_int(OF_ROWS, OF_COLS))) + 1,
    parameter int TS_W = $clog2(TIMESTEPS + 1),
    parameter int MC_W = $clog2(OF_ROWS * OF_COLS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ld_valid,
    input  logic [1:0]             ld_type,
    input  logic [15:0]            ld_addr,
    input  logic [DW-1:0]          ld_data,
    input  logic                   rd_valid,
    output logic                   rd_ready,
    input  logic [1:0]             rd_type,
    input  logic [RC_W-1:0]        rd_row,
    input  logic [RC_W-1:0]        rd_col,
    output logic                   rd_data_valid,
    output logic [DW-1:0]          rd_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   wr_type,
    input  logic [RC_W-1:0]        wr_row,
    input  logic [RC_W-1:0]        wr_col,
    input  logic [V_POT_WIDTH-1:0] wr_data,
    input  logic                   ts_valid,
    output logic                   ts_ready,
    output logic [TS_W-1:0]        ts_cur,
    output logic                   done,
    output logic                   err_oob,
    output logic                   err_type,
    output logic                   cmp_done,
    output logic [MC_W-1:0]        mismatch_cnt
);

    localparam int VP_N  = OF_ROWS * OF_COLS;
    localparam int F_N   = F_ROWS * F_COLS;
    localparam int IF_N  = TIMESTEPS * IF_ROWS * IF_COLS;
    localparam int OF_N  = TIMESTEPS * VP_N;
    localparam int VP_AW = addr_width(VP_N);
    localparam int F_AW  = addr_width(F_N);
    localparam int IF_AW = addr_width(IF_N);
    localparam int OF_AW = addr_width(OF_N);

    localparam logic [RC_W-1:0] OF_R = RC_W'(OF_ROWS);
    localparam logic [RC_W-1:0] OF_C = RC_W'(OF_COLS);
    localparam logic [RC_W-1:0] IF_R = RC_W'(IF_ROWS);
    localparam logic [RC_W-1:0] IF_C = RC_W'(IF_COLS);
    localparam logic [RC_W-1:0] F_R  = RC_W'(F_ROWS);
    localparam logic [RC_W-1:0] F_C  = RC_W'(F_COLS);
    localparam logic [TS_W-1:0] TS_LAST = TS_W'(TIMESTEPS - 1);

    logic [F_WIDTH-1:0]     filt_mem [F_N];
    logic                   if_mem   [IF_N];
    logic [V_POT_WIDTH-1:0] vpot     [VP_N];
    logic                   of_mem   [OF_N];

    logic run_started;
    logic rd_acc, wr_acc, ts_acc, ld_ok;
    logic vp_rd_in, if_rd_in, f_rd_in, wr_in;
    logic [VP_AW-1:0] vp_raddr, vp_waddr;
    logic [F_AW-1:0]  f_raddr;
    logic [IF_AW-1:0] if_raddr;
    logic [OF_AW-1:0] of_waddr;
    logic [DW-1:0]    rd_next;
    logic             rd_oob, rd_bad;

    assign rd_ready = ~done;
    assign wr_ready = ~done;
    assign ts_ready = ~done;
    assign rd_acc   = rd_valid & rd_ready;
    assign wr_acc   = wr_valid & wr_ready;
    assign ts_acc   = ts_valid & ts_ready;
    // Preload window closes permanently at the first datapath transfer.
    assign ld_ok    = ld_valid & (ts_cur == '0) & ~run_started;

    assign vp_rd_in = (rd_row < OF_R) && (rd_col < OF_C);
    assign if_rd_in = (rd_row < IF_R) && (rd_col < IF_C);
    assign f_rd_in  = (rd_row < F_R)  && (rd_col < F_C);
    assign wr_in    = (wr_row < OF_R) && (wr_col < OF_C);

    assign vp_raddr = VP_AW'(rd_row) * VP_AW'(OF_COLS) + VP_AW'(rd_col);
    assign vp_waddr = VP_AW'(wr_row) * VP_AW'(OF_COLS) + VP_AW'(wr_col);
    assign f_raddr  = F_AW'(rd_row) * F_AW'(F_COLS) + F_AW'(rd_col);
    assign if_raddr = IF_AW'(ts_cur) * IF_AW'(IF_ROWS * IF_COLS)
                    + IF_AW'(rd_row) * IF_AW'(IF_COLS) + IF_AW'(rd_col);
    assign of_waddr = OF_AW'(ts_cur) * OF_AW'(VP_N)
                    + OF_AW'(wr_row) * OF_AW'(OF_COLS) + OF_AW'(wr_col);

    always_comb begin
        rd_next = '0;
        rd_oob  = 1'b0;
        rd_bad  = 1'b0;
        case (rd_type)
            RD_VPOT:   if (vp_rd_in) rd_next = DW'(vpot[vp_raddr]);     else rd_oob = 1'b1;
            RD_IFMAP:  if (if_rd_in) rd_next = DW'(if_mem[if_raddr]);   else rd_oob = 1'b1;
            RD_FILTER: if (f_rd_in)  rd_next = DW'(filt_mem[f_raddr]);  else rd_oob = 1'b1;
            default:   rd_bad = 1'b1;
        endcase
    end

    // Filter and ifmap contents are preserved across reset.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            case (ld_type)
                LD_FILTER: if (ld_addr < 16'(F_N))  filt_mem[ld_addr[F_AW-1:0]] <= ld_data[F_WIDTH-1:0];
                LD_IFMAP:  if (ld_addr < 16'(IF_N)) if_mem[ld_addr[IF_AW-1:0]]  <= ld_data[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cur        <= '0;
            done          <= 1'b0;
            run_started   <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
            err_oob       <= 1'b0;
            err_type      <= 1'b0;
            for (int i = 0; i < VP_N; i++) vpot[i]   <= '0;
            for (int i = 0; i < OF_N; i++) of_mem[i] <= 1'b0;
        end else begin
            rd_data_valid <= rd_acc;
            rd_data       <= rd_acc ? rd_next : '0;
            err_oob       <= (rd_acc & rd_oob) | (wr_acc & ~wr_in);
            err_type      <= rd_acc & rd_bad;
            if (rd_acc | wr_acc | ts_acc)
                run_started <= 1'b1;
            if (ts_acc) begin
                ts_cur <= ts_cur + 1'b1;
                if (ts_cur == TS_LAST)
                    done <= 1'b1;
            end
            if (wr_acc && wr_in) begin
                if (wr_type == WR_VPOT)
                    vpot[vp_waddr] <= wr_data;
                else
                    of_mem[of_waddr] <= 1'b1;
            end
        end
    end

`ifdef SNN_TILE_MEM_GOLDEN_CMP_EN
    logic [VP_N-1:0] golden_mem;
    logic [VP_N-1:0] of_last;
    logic            done_q;

    always_ff @(posedge clk) begin
        if (ld_ok && ld_type == LD_GOLDEN && ld_addr < 16'(VP_N))
            golden_mem[ld_addr[VP_AW-1:0]] <= ld_data[0];
    end

    always_ff @(posedge clk) begin
        if (reset) done_q <= 1'b0;
        else       done_q <= done;
    end

    always_comb begin
        of_last = '0;
        for (int i = 0; i < VP_N; i++) of_last[i] = of_mem[(TIMESTEPS - 1) * VP_N + i];
    end

    snn_golden_cmp #(
        .N  (VP_N),
        .CW (MC_W)
    ) u_golden_cmp (
        .clk          (clk),
        .reset        (reset),
        .start        (done & ~done_q),
        .observed     (of_last),
        .expected     (golden_mem),
        .cmp_done     (cmp_done),
        .mismatch_cnt (mismatch_cnt)
    );
`else
    assign cmp_done     = 1'b0;
    assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_snn_tile_mem.sv
// Directed bench for snn_tile_mem: read responses go through a scoreboard queue
// checked by a monitor on the falling edge; control outputs are checked inline.
module tb_snn_tile_mem;
    import snn_mem_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_valid;
    logic [1:0] ld_type;
    logic [15:0] ld_addr;
    logic [7:0] ld_data;
    logic       rd_valid, rd_ready;
    logic [1:0] rd_type;
    logic [3:0] rd_row, rd_col;
    logic       rd_data_valid;
    logic [7:0] rd_data;
    logic       wr_valid, wr_ready, wr_type;
    logic [3:0] wr_row, wr_col;
    logic [7:0] wr_data;
    logic       ts_valid, ts_ready;
    logic [3:0] ts_cur;
    logic       done, err_oob, err_type, cmp_done;
    logic [3:0] mismatch_cnt;

    snn_tile_mem dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_type(ld_type), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_type(rd_type), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_type(wr_type), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data),
        .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_cur(ts_cur), .done(done),
        .err_oob(err_oob), .err_type(err_type), .cmp_done(cmp_done), .mismatch_cnt(mismatch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         oob;
        bit         typ;
        int         due;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   wr_oob_due = -1;
    int   n_pass = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every response must match the oldest outstanding request, one cycle after issue.
    always @(negedge clk) begin
        exp_t e;
        if (rd_data_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rd_data_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_latency"}, cyc, e.due);
                chk({e.name, "_data"}, rd_data, e.data);
                chk({e.name, "_err_oob"}, err_oob, e.oob || (cyc == wr_oob_due));
                chk({e.name, "_err_type"}, err_type, e.typ);
            end
        end else begin
            if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                chk({e.name, "_missing_response"}, 0, 1);
            end
            if (err_oob || cyc == wr_oob_due) chk("wr_err_oob", err_oob, cyc == wr_oob_due);
        end
    end

    task automatic clear_inputs();
        ld_valid = 0; rd_valid = 0; wr_valid = 0; ts_valid = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic tick();
        step(); clear_inputs();
    endtask

    task automatic do_ld(input logic [1:0] t, input int addr, input logic [7:0] d);
        ld_valid = 1; ld_type = t; ld_addr = 16'(addr); ld_data = d;
        tick();
    endtask

    task automatic set_rd(input string name, input logic [1:0] t, input int r, input int c,
                          input logic [7:0] d, input bit eo, input bit et);
        exp_t e;
        rd_valid = 1; rd_type = t; rd_row = 4'(r); rd_col = 4'(c);
        e.data = d; e.oob = eo; e.typ = et; e.due = cyc + 1; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic set_wr(input logic t, input int r, input int c, input logic [7:0] d, input bit eo);
        wr_valid = 1; wr_type = t; wr_row = 4'(r); wr_col = 4'(c); wr_data = d;
        if (eo) wr_oob_due = cyc + 1;
    endtask

    task automatic adv_ts(input int n);
        for (int i = 0; i < n; i++) begin
            ts_valid = 1;
            tick();
        end
    endtask

    initial begin
        int n;
        reset = 1;
        ld_type = 0; ld_addr = 0; ld_data = 0;
        rd_type = 0; rd_row = 0; rd_col = 0;
        wr_type = 0; wr_row = 0; wr_col = 0; wr_data = 0;
        clear_inputs();
        repeat (3) step();
        reset = 0;

        chk("rst_rd_ready", rd_ready, 1);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_ts_ready", ts_ready, 1);
        chk("rst_ts_cur", ts_cur, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_data_valid", rd_data_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_errs", {err_oob, err_type}, 0);
        chk("rst_cmp", {cmp_done, mismatch_cnt}, 0);

        // Preload: filter[i]=0x10+i except [1][2]=0x5A; ifmap spikes at t3(2,4) and t0(1,1); golden all 1.
        for (int i = 0; i < 9; i++) do_ld(LD_FILTER, i, (i == 5) ? 8'h5A : 8'(8'h10 + i));
        for (int t = 0; t < 10; t++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    do_ld(LD_IFMAP, 25 * t + 5 * r + c,
                          ((t == 3 && r == 2 && c == 4) || (t == 0 && r == 1 && c == 1)) ? 8'd1 : 8'd0);
        for (int i = 0; i < 9; i++) do_ld(LD_GOLDEN, i, 8'd1);

        // Back-to-back reads exercise the 1/cycle pipeline.
        set_rd("rd_filter_1_2", RD_FILTER, 1, 2, 8'h5A, 0, 0); step();
        set_rd("rd_filter_0_0", RD_FILTER, 0, 0, 8'h10, 0, 0); step();
        set_rd("rd_filter_2_2", RD_FILTER, 2, 2, 8'h18, 0, 0); step();
        set_rd("rd_ifmap_t0_1_1", RD_IFMAP, 1, 1, 8'h01, 0, 0); step();
        set_rd("rd_ifmap_t0_2_4", RD_IFMAP, 2, 4, 8'h00, 0, 0); tick();
        set_rd("rd_filter_oob_row", RD_FILTER, 3, 0, 8'h00, 1, 0); tick();
        set_rd("rd_filter_oob_col", RD_FILTER, 0, 3, 8'h00, 1, 0); tick();
        set_rd("rd_type3", 2'd3, 0, 0, 8'h00, 0, 1); tick();

        // Preload is closed once the run has started.
        do_ld(LD_FILTER, 5, 8'hFF);
        set_rd("rd_filter_after_late_ld", RD_FILTER, 1, 2, 8'h5A, 0, 0); tick();

        // Read-before-write on V_pot.
        set_rd("rd_vpot_same_cycle", RD_VPOT, 0, 0, 8'h00, 0, 0);
        set_wr(WR_VPOT, 0, 0, 8'd17, 0); tick();
        set_rd("rd_vpot_0_0", RD_VPOT, 0, 0, 8'd17, 0, 0);
        set_wr(WR_VPOT, 2, 2, 8'd200, 0); tick();
        set_rd("rd_vpot_2_2", RD_VPOT, 2, 2, 8'd200, 0, 0); tick();
        set_wr(WR_VPOT, 3, 0, 8'd99, 1); tick();
        repeat (2) tick();
        set_rd("rd_vpot_oob_5_0", RD_VPOT, 5, 0, 8'h00, 1, 0); tick();
        set_rd("rd_vpot_oob_2_3", RD_VPOT, 2, 3, 8'h00, 1, 0); tick();
        set_rd("rd_vpot_0_0_again", RD_VPOT, 0, 0, 8'd17, 0, 0); tick();

        // Timestep advance, and a read in the same cycle as an accept sees the old timestep.
        adv_ts(2);
        chk("ts_cur_2", ts_cur, 2);
        set_rd("rd_ifmap_t2_2_4", RD_IFMAP, 2, 4, 8'h00, 0, 0);
        ts_valid = 1; tick();
        chk("ts_cur_3", ts_cur, 3);
        set_rd("rd_ifmap_t3_2_4", RD_IFMAP, 2, 4, 8'h01, 0, 0); tick();
        set_rd("rd_ifmap_t3_1_1", RD_IFMAP, 1, 1, 8'h00, 0, 0); tick();

        adv_ts(6);
        chk("ts_cur_9", ts_cur, 9);
        chk("done_before_last", done, 0);
        // Spikes on 7 of 9 cells at t=9: (1,1) and (2,0) stay 0.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (!((r == 1 && c == 1) || (r == 2 && c == 0))) begin
                    set_wr(WR_OFSPIKE, r, c, 8'h00, 0); tick();
                end
        set_wr(WR_OFSPIKE, 0, 3, 8'h00, 1); tick();
        repeat (2) tick();

        ts_valid = 1; tick();
        chk("ts_cur_10", ts_cur, 10);
        chk("done_set", done, 1);
        chk("readies_low", {rd_ready, wr_ready, ts_ready}, 0);

        // Wait for the comparison, bounded.
        n = 0;
        rd_valid = 1; rd_type = RD_VPOT; rd_row = 0; rd_col = 0;
        ts_valid = 1; wr_valid = 1; wr_type = WR_VPOT;
        while (!cmp_done && n < 30) begin
            step();
            n++;
        end
        clear_inputs();
`ifdef SNN_TILE_MEM_GOLDEN_CMP_EN
        chk("cmp_done_latency", n, 10);
        chk("mismatch_cnt", mismatch_cnt, 2);
`else
        chk("cmp_done_disabled", cmp_done, 0);
        chk("mismatch_cnt_disabled", mismatch_cnt, 0);
`endif
        chk("ts_cur_held_after_done", ts_cur, 10);
        chk("done_sticky", done, 1);

        // Reset together with a read: reset wins and no response appears.
        rd_valid = 1; rd_type = RD_FILTER; rd_row = 0; rd_col = 0;
        reset = 1; tick();
        reset = 0;
        chk("rerst_ts_cur", ts_cur, 0);
        chk("rerst_done", done, 0);
        chk("rerst_readies", {rd_ready, wr_ready, ts_ready}, 3'b111);
        chk("rerst_rd_data_valid", rd_data_valid, 0);
        chk("rerst_cmp", {cmp_done, mismatch_cnt}, 0);
        set_rd("rd_filter_retained", RD_FILTER, 1, 2, 8'h5A, 0, 0); step();
        set_rd("rd_vpot_cleared", RD_VPOT, 2, 2, 8'h00, 0, 0); tick();
        repeat (3) tick();
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
